// File: rtl/acc_icb_pkg.sv
// Shared IDs, grant-state encoding and round-robin helpers for the ICB arbiter slice.
// Pure declarations; no logic or latency of its own.
package acc_icb_pkg;

    localparam int NUM_REQ = 3;
    localparam int ID_W    = 2;

    localparam logic [ID_W-1:0] ID_WEIGHT = 2'd0;
    localparam logic [ID_W-1:0] ID_IMAP   = 2'd1;
    localparam logic [ID_W-1:0] ID_OMAP   = 2'd2;

    typedef enum logic {
        GS_IDLE = 1'b0,
        GS_LOCK = 1'b1
    } gnt_state_e;

    function automatic int tag_w(input int aw);
        return ID_W + aw;
    endfunction

    function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
        return (id == ID_OMAP) ? ID_WEIGHT : id + 2'd1;
    endfunction

    // First asserted requester at or after ptr, wrapping 0->1->2->0.
    function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] vld,
                                                input logic [ID_W-1:0]    ptr);
        logic [ID_W-1:0] pick;
        logic [2:0]      sum;
        pick = ID_WEIGHT;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            sum = {1'b0, ptr} + 3'(k);
            if (sum >= 3'(NUM_REQ)) sum = sum - 3'(NUM_REQ);
            if (vld[sum[ID_W-1:0]]) pick = sum[ID_W-1:0];
        end
        return pick;
    endfunction

endpackage

// File: rtl/icb_tag_fifo.sv
// Synchronous tag FIFO holding {id,addr} of each issued ICB command.
// Head is combinational from registered storage; push while full and pop while empty are ignored.
// Full is purely occupancy-based, so a same-cycle pop does not admit a push.
module icb_tag_fifo #(
    parameter int WIDTH = 34,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] head_dat,
    output logic             full,
    output logic             empty
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr;
    logic [PW-1:0]    r_rd;
    logic [PW:0]      r_cnt;
    logic             w_push;
    logic             w_pop;

    assign full     = (r_cnt == (PW + 1)'(DEPTH));
    assign empty    = (r_cnt == '0);
    assign w_push   = push && !full;
    assign w_pop    = pop && !empty;
    assign head_dat = r_mem[r_rd];

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr] <= push_dat;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + PW'(1);
            if (w_pop)  r_rd <= r_rd + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + (PW + 1)'(1);
                2'b01:   r_cnt <= r_cnt - (PW + 1)'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

// File: rtl/icb_arb_sched.sv
// Burst-locked round-robin share of one ICB master among weight/imap/omap BIUs; optional ICB_ARB_ERR_CNT_EN error counter.
// Command path is 0-cycle combinational; responses return in issue order via the tag FIFO.
// Full tag FIFO blocks issue; a stalled reader stalls only the response channel.
module icb_arb_sched
    import acc_icb_pkg::*;
#(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int OSTD_DEPTH = 4,
    parameter int BURST_MAX  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req_vld,
    output logic [NUM_REQ-1:0]    req_rdy,
    input  logic [NUM_REQ*AW-1:0] req_addr,
    input  logic [DW-1:0]         omap_wdata,
    output logic [1:0]            rsp_vld,
    input  logic [1:0]            rsp_rdy,
    output logic [AW-1:0]         rsp_addr,
    output logic [DW-1:0]         rsp_data,
`ifdef ICB_ARB_ERR_CNT_EN
    output logic [15:0]           err_cnt,
    output logic                  err_sticky,
    input  logic                  err_clr,
`endif
    output logic                  icb_cmd_valid,
    input  logic                  icb_cmd_ready,
    output logic [AW-1:0]         icb_cmd_addr,
    output logic                  icb_cmd_read,
    output logic [DW-1:0]         icb_cmd_wdata,
    output logic [DW/8-1:0]       icb_cmd_wmask,
    input  logic                  icb_rsp_valid,
    output logic                  icb_rsp_ready,
    input  logic                  icb_rsp_err,
    input  logic [DW-1:0]         icb_rsp_rdata
);

    localparam int              TW         = tag_w(AW);
    localparam int              CW         = $clog2(BURST_MAX + 1);
    localparam logic [CW-1:0]   BURST_LAST = CW'(BURST_MAX - 1);

    gnt_state_e       r_state;
    logic [ID_W-1:0]  r_gnt;
    logic [ID_W-1:0]  r_rr;
    logic [CW-1:0]    r_cnt;
    logic             r_en;

    logic             w_keep;
    logic             w_any;
    logic [ID_W-1:0]  w_ptr;
    logic [ID_W-1:0]  w_id;
    logic [CW-1:0]    w_cnt_base;
    logic             w_full;
    logic             w_empty;
    logic             w_cmd_hs;
    logic             w_rsp_hs;
    logic [TW-1:0]    w_head;
    logic [ID_W-1:0]  w_head_id;
    logic [AW-1:0]    w_addr_arr [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_addr
        assign w_addr_arr[i] = req_addr[i*AW +: AW];
    end

    // A lock whose owner dropped valid re-arbitrates from the next id in the same cycle.
    always_comb begin
        w_keep     = (r_state == GS_LOCK) && req_vld[r_gnt];
        w_ptr      = (r_state == GS_LOCK) ? next_id(r_gnt) : r_rr;
        w_any      = r_en && (|req_vld);
        w_id       = w_keep ? r_gnt : rr_pick(req_vld, w_ptr);
        w_cnt_base = w_keep ? r_cnt : '0;
    end

    assign icb_cmd_valid = w_any && !w_full;
    assign w_cmd_hs      = icb_cmd_valid && icb_cmd_ready;
    assign icb_cmd_addr  = w_addr_arr[w_id];
    assign icb_cmd_read  = (w_id != ID_OMAP);
    assign icb_cmd_wdata = omap_wdata;
    assign icb_cmd_wmask = (w_id == ID_OMAP) ? '1 : '0;

    always_comb begin
        req_rdy       = '0;
        req_rdy[w_id] = w_cmd_hs;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_en    <= 1'b0;
            r_state <= GS_IDLE;
            r_gnt   <= ID_WEIGHT;
            r_rr    <= ID_WEIGHT;
            r_cnt   <= '0;
        end else begin
            r_en <= 1'b1;
            if (w_any) begin
                if (w_cmd_hs && (w_cnt_base == BURST_LAST)) begin
                    r_state <= GS_IDLE;
                    r_rr    <= next_id(w_id);
                    r_cnt   <= '0;
                end else begin
                    r_state <= GS_LOCK;
                    r_gnt   <= w_id;
                    r_cnt   <= w_cmd_hs ? w_cnt_base + CW'(1) : w_cnt_base;
                end
            end else begin
                if (r_state == GS_LOCK) r_rr <= next_id(r_gnt);
                r_state <= GS_IDLE;
                r_cnt   <= '0;
            end
        end
    end

    icb_tag_fifo #(
        .WIDTH (TW),
        .DEPTH (OSTD_DEPTH)
    ) u_tag_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (w_cmd_hs),
        .push_dat ({w_id, icb_cmd_addr}),
        .pop      (w_rsp_hs),
        .head_dat (w_head),
        .full     (w_full),
        .empty    (w_empty)
    );

    assign w_head_id = w_head[TW-1 -: ID_W];
    assign rsp_addr  = w_head[AW-1:0];
    assign rsp_data  = icb_rsp_rdata;
    assign w_rsp_hs  = icb_rsp_valid && icb_rsp_ready;

    // Write responses have no consumer, so the omap head is drained unconditionally.
    always_comb begin
        rsp_vld       = '0;
        icb_rsp_ready = 1'b0;
        if (!w_empty) begin
            case (w_head_id)
                ID_WEIGHT: begin
                    rsp_vld[0]    = icb_rsp_valid;
                    icb_rsp_ready = rsp_rdy[0];
                end
                ID_IMAP: begin
                    rsp_vld[1]    = icb_rsp_valid;
                    icb_rsp_ready = rsp_rdy[1];
                end
                default: icb_rsp_ready = 1'b1;
            endcase
        end
    end

`ifdef ICB_ARB_ERR_CNT_EN
    logic [15:0] r_err_cnt;
    logic        r_err_sticky;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_cnt    <= '0;
            r_err_sticky <= 1'b0;
        end else if (w_rsp_hs && icb_rsp_err) begin
            r_err_sticky <= 1'b1;
            if (err_clr)                   r_err_cnt <= 16'd1;
            else if (r_err_cnt != 16'hFFFF) r_err_cnt <= r_err_cnt + 16'd1;
        end else if (err_clr) begin
            r_err_sticky <= 1'b0;
        end
    end

    assign err_cnt    = r_err_cnt;
    assign err_sticky = r_err_sticky;
`else
    logic w_unused_err;
    assign w_unused_err = icb_rsp_err;
`endif

endmodule

// File: tb/tb_icb_arb_sched.sv
// Randomised scoreboard bench for icb_arb_sched: requester/fabric drivers, reference grant model, in-order response queue.
module tb_icb_arb_sched;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int OSTD = 4;
    localparam int BMAX = 8;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b1;
    logic [2:0]    req_vld = '0;
    logic [2:0]    req_rdy;
    logic [3*AW-1:0] req_addr = '0;
    logic [DW-1:0] omap_wdata = '0;
    logic [1:0]    rsp_vld;
    logic [1:0]    rsp_rdy = '0;
    logic [AW-1:0] rsp_addr;
    logic [DW-1:0] rsp_data;
    logic          icb_cmd_valid;
    logic          icb_cmd_ready = 1'b0;
    logic [AW-1:0] icb_cmd_addr;
    logic          icb_cmd_read;
    logic [DW-1:0] icb_cmd_wdata;
    logic [DW/8-1:0] icb_cmd_wmask;
    logic          icb_rsp_valid = 1'b0;
    logic          icb_rsp_ready;
    logic          icb_rsp_err = 1'b0;
    logic [DW-1:0] icb_rsp_rdata = '0;
`ifdef ICB_ARB_ERR_CNT_EN
    logic [15:0]   err_cnt;
    logic          err_sticky;
    logic          err_clr = 1'b0;
    int            m_err = 0;
    bit            m_sticky = 1'b0;
`endif

    always #5 clk = ~clk;

    icb_arb_sched #(
        .AW(AW), .DW(DW), .OSTD_DEPTH(OSTD), .BURST_MAX(BMAX)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_vld(req_vld), .req_rdy(req_rdy), .req_addr(req_addr), .omap_wdata(omap_wdata),
        .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_addr(rsp_addr), .rsp_data(rsp_data),
`ifdef ICB_ARB_ERR_CNT_EN
        .err_cnt(err_cnt), .err_sticky(err_sticky), .err_clr(err_clr),
`endif
        .icb_cmd_valid(icb_cmd_valid), .icb_cmd_ready(icb_cmd_ready), .icb_cmd_addr(icb_cmd_addr),
        .icb_cmd_read(icb_cmd_read), .icb_cmd_wdata(icb_cmd_wdata), .icb_cmd_wmask(icb_cmd_wmask),
        .icb_rsp_valid(icb_rsp_valid), .icb_rsp_ready(icb_rsp_ready), .icb_rsp_err(icb_rsp_err),
        .icb_rsp_rdata(icb_rsp_rdata)
    );

    typedef struct packed {
        logic [1:0]    id;
        logic [AW-1:0] addr;
    } tag_t;

    tag_t exp_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    // Stimulus knobs (percent probabilities)
    int p_req = 0, p_crdy = 100, p_rvld = 100, p_rrdy = 100, p_clr = 0;
    bit run = 1'b0, burst_chk = 1'b0;

    bit            has [3];
    logic [AW-1:0] raddr [3];
    bit            hs_req [3];
    bit            hs_cmd = 1'b0, hs_rsp = 1'b0;
    int            fab_cnt = 0;
    int            cmd_obs = 0;

    // Reference grant state: owner (-1 = none), beats in current burst, rr pointer
    int own = -1, m_cnt = 0, m_ptr = 0;
    int last_id = -1, run_len = 0;

    int   mp, m_act;
    bit   m_full, m_cvld, m_crhs, m_rhs;
    tag_t m_head;
    logic [2:0] m_erdy;
    logic [1:0] m_ervld;
    logic       m_ersp_rdy;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    endtask

    function automatic int model_pick();
        int start;
        if (own >= 0 && req_vld[own]) return own;
        start = (own >= 0) ? (own + 1) % 3 : m_ptr;
        for (int k = 0; k < 3; k++)
            if (req_vld[(start + k) % 3]) return (start + k) % 3;
        return -1;
    endfunction

    function automatic bit chance(input int pct);
        return int'($urandom_range(0, 99)) < pct;
    endfunction

    // Requester and fabric drivers: update just after the active edge
    always @(posedge clk) begin
        if (run) begin
            #1;
            for (int i = 0; i < 3; i++) begin
                if (hs_req[i]) has[i] = 1'b0;
                hs_req[i] = 1'b0;
                if (!has[i] && chance(p_req)) begin
                    has[i]   = 1'b1;
                    raddr[i] = $urandom & ~32'h3;
                    if (i == 2) omap_wdata = $urandom;
                end
                req_vld[i]            = has[i];
                req_addr[i*AW +: AW]  = raddr[i];
            end
            if (hs_cmd) fab_cnt++;
            if (hs_rsp) begin
                fab_cnt--;
                icb_rsp_valid = 1'b0;
            end
            hs_cmd = 1'b0;
            hs_rsp = 1'b0;
            if (!icb_rsp_valid && fab_cnt > 0 && chance(p_rvld)) begin
                icb_rsp_valid = 1'b1;
                icb_rsp_rdata = $urandom;
                icb_rsp_err   = ($urandom_range(0, 3) == 0);
            end
            icb_cmd_ready = chance(p_crdy);
            rsp_rdy[0]    = chance(p_rrdy);
            rsp_rdy[1]    = chance(p_rrdy);
`ifdef ICB_ARB_ERR_CNT_EN
            err_clr = chance(p_clr);
`endif
        end
    end

    // Monitor / scoreboard: sample on the falling edge
    always @(negedge clk) begin
        if (run) begin
            mp     = model_pick();
            m_full = exp_q.size() >= OSTD;
            m_cvld = (mp >= 0) && !m_full;
            check("cmd_valid", icb_cmd_valid, m_cvld);
            m_erdy = (m_cvld && icb_cmd_ready) ? (3'b001 << mp) : 3'b000;
            check("req_rdy", req_rdy, m_erdy);
            if (m_cvld) begin
                check("cmd_addr", icb_cmd_addr, raddr[mp]);
                check("cmd_read", icb_cmd_read, mp != 2);
                check("cmd_wmask", icb_cmd_wmask, (mp == 2) ? 4'hF : 4'h0);
                if (mp == 2) check("cmd_wdata", icb_cmd_wdata, omap_wdata);
            end

            m_ersp_rdy = 1'b0;
            m_ervld    = 2'b00;
            m_head     = '0;
            if (exp_q.size() > 0) begin
                m_head = exp_q[0];
                if (m_head.id == 2'd2) m_ersp_rdy = 1'b1;
                else begin
                    m_ersp_rdy              = rsp_rdy[m_head.id[0]];
                    m_ervld[m_head.id[0]]   = icb_rsp_valid;
                end
            end
            check("icb_rsp_ready", icb_rsp_ready, m_ersp_rdy);
            check("rsp_vld", rsp_vld, m_ervld);
            if (m_ervld != 2'b00) begin
                check("rsp_addr", rsp_addr, m_head.addr);
                check("rsp_data", rsp_data, icb_rsp_rdata);
            end
`ifdef ICB_ARB_ERR_CNT_EN
            check("err_cnt", err_cnt, m_err);
            check("err_sticky", err_sticky, m_sticky);
`endif
            m_crhs = m_cvld && icb_cmd_ready;
            m_rhs  = icb_rsp_valid && m_ersp_rdy;

            if (icb_cmd_valid && icb_cmd_ready) cmd_obs++;
            if (burst_chk && icb_cmd_valid && icb_cmd_ready) begin
                m_act = req_rdy[0] ? 0 : (req_rdy[1] ? 1 : 2);
                if (m_act != last_id) begin
                    if (last_id < 0) check("first_gnt", m_act, 0);
                    else begin
                        check("burst_len", run_len, BMAX);
                        check("rotate", m_act, (last_id + 1) % 3);
                    end
                    last_id = m_act;
                    run_len = 1;
                end else run_len++;
            end

`ifdef ICB_ARB_ERR_CNT_EN
            if (m_rhs && icb_rsp_err) begin
                m_sticky = 1'b1;
                m_err    = err_clr ? 1 : ((m_err < 65535) ? m_err + 1 : m_err);
            end else if (err_clr) m_sticky = 1'b0;
`endif
            if (m_rhs) begin
                void'(exp_q.pop_front());
                hs_rsp = 1'b1;
            end
            if (m_crhs) begin
                exp_q.push_back({mp[1:0], raddr[mp]});
                hs_req[mp] = 1'b1;
                hs_cmd     = 1'b1;
            end

            if (mp >= 0) begin
                if (mp != own) begin
                    own   = mp;
                    m_cnt = 0;
                end
                if (m_crhs) begin
                    m_cnt++;
                    if (m_cnt == BMAX) begin
                        own   = -1;
                        m_ptr = (mp + 1) % 3;
                        m_cnt = 0;
                    end
                end
            end else begin
                if (own >= 0) m_ptr = (own + 1) % 3;
                own   = -1;
                m_cnt = 0;
            end
        end
    end

    task automatic drain();
        bit busy;
        p_req = 0; p_crdy = 100; p_rvld = 100; p_rrdy = 100; p_clr = 0;
        busy = 1'b1;
        for (int c = 0; c < 400 && busy; c++) begin
            @(posedge clk);
            busy = (exp_q.size() != 0) || has[0] || has[1] || has[2];
        end
        check("drain_timeout", busy, 1'b0);
        @(negedge clk);
        check("drain_rsp_ready", icb_rsp_ready, 1'b0);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_rdy", req_rdy, 3'b000);
        check("rst_rsp_vld", rsp_vld, 2'b00);
        check("rst_cmd_valid", icb_cmd_valid, 1'b0);
        check("rst_rsp_ready", icb_rsp_ready, 1'b0);
        req_vld       = 3'b111;
        icb_cmd_ready = 1'b1;
        #1;
        check("rst_cmd_valid_req", icb_cmd_valid, 1'b0);
        check("rst_req_rdy_req", req_rdy, 3'b000);
        req_vld       = 3'b000;
        icb_cmd_ready = 1'b0;
`ifdef ICB_ARB_ERR_CNT_EN
        check("rst_err_cnt", err_cnt, 16'd0);
        check("rst_err_sticky", err_sticky, 1'b0);
`endif
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #2 run = 1'b1;

        // Saturated requesters, free-flowing fabric: 8/8/8 rotation with no idle cycle
        p_req = 100; p_crdy = 100; p_rvld = 100; p_rrdy = 100;
        burst_chk = 1'b1;
        repeat (80) @(posedge clk);
        burst_chk = 1'b0;
        drain();

        // Responses withheld: exactly OSTD commands may issue
        p_rvld  = 0;
        cmd_obs = 0;
        p_req   = 100;
        repeat (20) @(posedge clk);
        check("ostd_cmds", cmd_obs, OSTD);
        p_rvld = 100;
        p_rrdy = 0;
        repeat (30) @(posedge clk);
        p_rrdy = 100;
        drain();

        // Random mix
        p_req = 40; p_crdy = 70; p_rvld = 60; p_rrdy = 70; p_clr = 5;
        repeat (3000) @(posedge clk);
        drain();

        // Reset in the middle of traffic
        p_req = 100; p_crdy = 100; p_rvld = 0;
        repeat (6) @(posedge clk);
        #2;
        run   = 1'b0;
        rst_n = 1'b0;
        #1;
        check("mid_rst_cmd_valid", icb_cmd_valid, 1'b0);
        check("mid_rst_req_rdy", req_rdy, 3'b000);
        check("mid_rst_rsp_vld", rsp_vld, 2'b00);
        check("mid_rst_rsp_ready", icb_rsp_ready, 1'b0);
`ifdef ICB_ARB_ERR_CNT_EN
        check("mid_rst_err_cnt", err_cnt, 16'd0);
        check("mid_rst_err_sticky", err_sticky, 1'b0);
`endif
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
